// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared types and helpers for the MFCC front end.
//   framer_state_t     - pre_emphasis_framer FSM states
//   PREEMPH_ALPHA_Q15  - default pre-emphasis coefficient (0.97, unsigned Q1.15)
//   saturate()         - clamps a signed value into a signed range of 'width' bits
package mfcc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ANNOUNCE = 2'd1,
    SERVE    = 2'd2,
    ADVANCE  = 2'd3
  } framer_state_t;

  localparam logic [15:0] PREEMPH_ALPHA_Q15 = 16'h7C29;

  // Clamp v to [-2^(width-1), 2^(width-1)-1]; width must be in 2..31.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/framer_ram.sv
// framer_ram: simple dual-port RAM, DEPTH x WIDTH.
//   clk           clock
//   rst           synchronous active-high reset (clears the read data register only)
//   we/waddr/wdata synchronous write port
//   re/raddr      read request; rdata is registered and valid one cycle later
module framer_ram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pre_emphasis_framer.sv
// pre_emphasis_framer: y[n] = x[n] - alpha*x[n-1] with saturation, stored in a
// circular buffer and served as overlapping frames of FRAME_LEN samples that
// advance by HOP_SIZE.
//   clk, rst         clock, synchronous active-high reset
//   sample_i         raw signed audio sample, sample_valid_i qualifies it
//   start_o          1-cycle pulse: a frame is ready
//   rd_en_i          consumer requests the next frame sample
//   frame_sample_o   frame sample, frame_valid_o marks it (1 cycle after rd_en_i)
//   busy_o           FSM not idle
//   overflow_o       sticky: a sample was dropped on a full buffer
//   fill_level_o     samples stored from frame_base to wr_ptr
module pre_emphasis_framer
  import mfcc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FRAME_LEN    = 306,
  parameter int unsigned HOP_SIZE     = 122,
  parameter int unsigned BUF_DEPTH    = 512,
  parameter logic [15:0] ALPHA_Q15    = PREEMPH_ALPHA_Q15,
  parameter int unsigned BUF_LOG2     = $clog2(BUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    start_o,
  input  logic                    rd_en_i,
  output logic [SAMPLE_WIDTH-1:0] frame_sample_o,
  output logic                    frame_valid_o,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [BUF_LOG2:0]       fill_level_o
);

  localparam int unsigned PTR_W  = BUF_LOG2 + 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned PROD_W = 2 * SAMPLE_WIDTH + 1;
  localparam int unsigned DIFF_W = SAMPLE_WIDTH + 2;

  framer_state_t state;

  logic [SAMPLE_WIDTH-1:0] prev_sample;
  logic [SAMPLE_WIDTH-1:0] y_q;
  logic                    y_valid_q;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        frame_base;
  logic [PTR_W-1:0]        fill;
  logic [PTR_W-1:0]        rd_sum;
  logic [CNT_W-1:0]        rd_cnt;
  logic                    wr_ok;
  logic                    rd_fire;

  // Pre-emphasis datapath
  logic signed [PROD_W-1:0] prev_ext;
  logic signed [PROD_W-1:0] alpha_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_shr;
  logic signed [DIFF_W-1:0] x_ext;
  logic signed [DIFF_W-1:0] diff;
  logic signed [31:0]       sat;
  logic [SAMPLE_WIDTH-1:0]  y_next;
  logic                     unused_bits;

  always_comb begin
    prev_ext  = {{(PROD_W - SAMPLE_WIDTH){prev_sample[SAMPLE_WIDTH-1]}}, prev_sample};
    alpha_ext = {{(PROD_W - 16){1'b0}}, ALPHA_Q15};
    prod      = prev_ext * alpha_ext;
    prod_shr  = prod >>> 15;
    x_ext     = {{2{sample_i[SAMPLE_WIDTH-1]}}, sample_i};
    diff      = x_ext - prod_shr[DIFF_W-1:0];
    sat       = saturate({{(32 - DIFF_W){diff[DIFF_W-1]}}, diff}, SAMPLE_WIDTH);
    y_next    = sat[SAMPLE_WIDTH-1:0];
  end

  // Pointers are one bit wider than the RAM address so full and empty differ.
  assign fill         = wr_ptr - frame_base;
  assign fill_level_o = fill;
  assign wr_ok        = y_valid_q && (fill < PTR_W'(BUF_DEPTH));
  assign rd_fire      = (state == SERVE) && rd_en_i && (rd_cnt < CNT_W'(FRAME_LEN));
  assign rd_sum       = frame_base + PTR_W'(rd_cnt);
  assign busy_o       = (state != IDLE);
  assign unused_bits  = ^{prod_shr[PROD_W-1:DIFF_W], sat[31:SAMPLE_WIDTH], rd_sum[BUF_LOG2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sample <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
    end else begin
      y_valid_q <= sample_valid_i;
      if (sample_valid_i) begin
        y_q         <= y_next;
        prev_sample <= sample_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (y_valid_q) begin
      if (wr_ok) wr_ptr     <= wr_ptr + PTR_W'(1);
      else       overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      frame_base    <= '0;
      rd_cnt        <= '0;
      start_o       <= 1'b0;
      frame_valid_o <= 1'b0;
    end else begin
      start_o       <= 1'b0;
      frame_valid_o <= rd_fire;
      case (state)
        IDLE: begin
          if (fill >= PTR_W'(FRAME_LEN)) begin
            state   <= ANNOUNCE;
            start_o <= 1'b1;
          end
        end
        ANNOUNCE: begin
          rd_cnt <= '0;
          state  <= SERVE;
        end
        SERVE: begin
          if (rd_cnt == CNT_W'(FRAME_LEN)) state  <= ADVANCE;
          else if (rd_fire)                rd_cnt <= rd_cnt + CNT_W'(1);
        end
        ADVANCE: begin
          frame_base <= frame_base + PTR_W'(HOP_SIZE);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  framer_ram #(
    .DEPTH  (BUF_DEPTH),
    .WIDTH  (SAMPLE_WIDTH),
    .ADDR_W (BUF_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[BUF_LOG2-1:0]),
    .wdata (y_q),
    .re    (rd_fire),
    .raddr (rd_sum[BUF_LOG2-1:0]),
    .rdata (frame_sample_o)
  );

endmodule

// File: tb/tb_pre_emphasis_framer.sv
// tb_pre_emphasis_framer: directed bench for pre_emphasis_framer with default
// parameters. Expected pre-emphasis values come from hand-computed constants and
// a small integer reference model (floor division, explicit clamping).
module tb_pre_emphasis_framer;

  logic        clk;
  logic        rst;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        start_o;
  logic        rd_en_i;
  logic [15:0] frame_sample_o;
  logic        frame_valid_o;
  logic        busy_o;
  logic        overflow_o;
  logic [9:0]  fill_level_o;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int valid_cnt = 0;

  logic [15:0] exp_y [0:1023];
  logic [15:0] got   [0:511];
  int n_got, first_cyc, last_cyc;
  int mprev, nexp;
  int v0, s0;

  pre_emphasis_framer dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .start_o        (start_o),
    .rd_en_i        (rd_en_i),
    .frame_sample_o (frame_sample_o),
    .frame_valid_o  (frame_valid_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .fill_level_o   (fill_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_o)       start_cnt++;
    if (frame_valid_o) valid_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [15:0] gen(input int n);
    case (n)
      0, 1, 2: gen = 16'sd1000;
      3:       gen = 16'sd32767;
      4:       gen = -16'sd32768;
      5:       gen = 16'sd32767;
      default: gen = 16'(n * 37 - 5000);
    endcase
  endfunction

  function automatic logic [15:0] model_y(input int prev, input int x);
    longint p, q, d;
    p = longint'(prev) * 64'sd31785;
    q = p / 64'sd32768;
    if (p < 0 && q * 64'sd32768 != p) q = q - 1;
    d = longint'(x) - q;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  task automatic feed(input int n0, input int count);
    logic signed [15:0] x;
    for (int n = n0; n < n0 + count; n++) begin
      x = gen(n);
      exp_y[nexp] = model_y(mprev, int'(x));
      mprev = int'(x);
      nexp++;
      sample_i = x;
      sample_valid_i = 1'b1;
      tick();
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid_i = 1'b0;
    rd_en_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mprev = 0;
    nexp = 0;
  endtask

  // Collect up to 'limit' valid samples within 'budget' cycles.
  task automatic read_frame(input int limit, input int budget, input bit stall);
    int c;
    c = 0;
    n_got = 0;
    while (n_got < limit && c < budget) begin
      rd_en_i = stall ? (c % 3 != 2) : 1'b1;
      tick();
      c++;
      if (frame_valid_o) begin
        if (n_got == 0) first_cyc = c;
        last_cyc = c;
        got[n_got] = frame_sample_o;
        n_got++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int off);
    int mism;
    mism = 0;
    for (int i = 0; i < n_got; i++)
      if (got[i] !== exp_y[off + i]) mism++;
    check({tag, "_count"}, 32'(n_got), 32'd306);
    check({tag, "_data_mismatches"}, 32'(mism), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"},    32'(start_o),        32'd0);
    check({tag, "_valid"},    32'(frame_valid_o),  32'd0);
    check({tag, "_sample"},   32'(frame_sample_o), 32'd0);
    check({tag, "_busy"},     32'(busy_o),         32'd0);
    check({tag, "_overflow"}, 32'(overflow_o),     32'd0);
    check({tag, "_fill"},     32'(fill_level_o),   32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sample_i = '0;
    sample_valid_i = 1'b0;
    rd_en_i = 1'b0;
    mprev = 0;
    nexp = 0;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // One full frame with rd_en_i held high: values, start timing, back-to-back valids
    v0 = valid_cnt;
    s0 = start_cnt;
    rd_en_i = 1'b1;
    feed(0, 306);
    check("t3_start_k0", 32'(start_o), 32'd0);
    tick();
    check("t3_start_k1", 32'(start_o), 32'd0);
    tick();
    check("t3_start_k2", 32'(start_o), 32'd1);
    check("t3_busy_announce", 32'(busy_o), 32'd1);
    read_frame(306, 400, 1'b0);
    check("y0_const", 32'(got[0]), 32'h03E8);
    check("y1_const", 32'(got[1]), 32'd30);
    check("y2_const", 32'(got[2]), 32'd30);
    check("y3_jump",  32'(got[3]), 32'h7C35);
    check("y4_satneg", 32'(got[4]), 32'h8000);
    check("y5_satpos", 32'(got[5]), 32'h7FFF);
    check("y6_satneg", 32'(got[6]), 32'h8000);
    check_frame("t3_frame", 0);
    check("t3_back_to_back", 32'(last_cyc - first_cyc + 1), 32'd306);
    for (int i = 0; i < 10; i++) tick();
    check("t3_total_valids", 32'(valid_cnt - v0), 32'd306);
    check("t3_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("t3_busy_after", 32'(busy_o), 32'd0);
    check("t3_fill_after", 32'(fill_level_o), 32'd184);
    rd_en_i = 1'b0;

    // Two overlapping frames, first one read with stalls
    do_reset();
    feed(0, 428);
    tick();
    tick();
    check("t4_fill_428", 32'(fill_level_o), 32'd428);
    read_frame(306, 2000, 1'b1);
    check_frame("t4_frame1", 0);
    read_frame(306, 1000, 1'b0);
    check_frame("t4_frame2", 122);
    check("t4_frame2_first", 32'(got[0]), 32'd22);
    check("t4_frame2_back_to_back", 32'(last_cyc - first_cyc + 1), 32'd306);
    rd_en_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_fill_after", 32'(fill_level_o), 32'd184);
    check("t4_busy_after", 32'(busy_o), 32'd0);

    // Overflow: 513 samples with no reads
    do_reset();
    feed(0, 512);
    tick();
    tick();
    check("t5_fill_512", 32'(fill_level_o), 32'd512);
    check("t5_no_overflow_yet", 32'(overflow_o), 32'd0);
    feed(512, 1);
    tick();
    tick();
    check("t5_overflow_set", 32'(overflow_o), 32'd1);
    check("t5_fill_still_512", 32'(fill_level_o), 32'd512);
    for (int i = 0; i < 5; i++) tick();
    check("t5_overflow_sticky", 32'(overflow_o), 32'd1);
    read_frame(306, 1000, 1'b0);
    check_frame("t5_frame", 0);
    rd_en_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_fill_after", 32'(fill_level_o), 32'd390);
    check("t5_overflow_after_read", 32'(overflow_o), 32'd1);

    // Reset in the middle of a frame
    do_reset();
    rd_en_i = 1'b1;
    feed(0, 306);
    read_frame(100, 400, 1'b0);
    check("t6_partial_count", 32'(n_got), 32'd100);
    rst = 1'b1;
    tick();
    check_idle_outputs("t6_reset");
    rst = 1'b0;
    mprev = 0;
    nexp = 0;
    v0 = valid_cnt;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_valids", 32'(valid_cnt - v0), 32'd0);
    check("t6_busy_low", 32'(busy_o), 32'd0);
    rd_en_i = 1'b0;
    feed(0, 305);
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_start_305", 32'(start_cnt - s0), 32'd0);
    check("t6_fill_305", 32'(fill_level_o), 32'd305);
    feed(305, 1);
    for (int i = 0; i < 3; i++) tick();
    check("t6_start_306", 32'(start_cnt - s0), 32'd1);
    check("t6_busy_306", 32'(busy_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
